xadc_drp_scheduler: RTL and testbench

Sequences all XADC DRP traffic and shares the single DRP port between two requesters: the continuous sample path, which reads the result register of the channel that just converted on every end of conversion, and a host configuration port for register reads and writes. It sits between the XADC primitive/wizard DRP pins and the rest of the receiver datapath. It replaces the direct tie of DEN to EOC and adds arbitration, overrun detection and a DRP timeout.

---
 rtl/xadc_pkg.sv | 32 +++
 rtl/xadc_drp_scheduler.sv | 210 +++++++++++++++++++++
 tb/tb_xadc_drp_scheduler.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xadc_pkg.sv
// Shared types and constants for the XADC DRP scheduler.
package xadc_pkg;

    localparam int DRP_AW   = 7;
    localparam int DRP_DW   = 16;
    localparam int SAMPLE_W = 12;
    localparam int CHAN_W   = 5;

    // XADC DRP register map: status/result registers and configuration registers.
    localparam logic [DRP_AW-1:0] ADDR_STATUS_FIRST = 7'h00;
    localparam logic [DRP_AW-1:0] ADDR_STATUS_LAST  = 7'h1F;
    localparam logic [DRP_AW-1:0] ADDR_CFG0         = 7'h40;
    localparam logic [DRP_AW-1:0] ADDR_CFG1         = 7'h41;
    localparam logic [DRP_AW-1:0] ADDR_CFG2         = 7'h42;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_e;

    typedef enum logic {
        OWN_SAMPLE,
        OWN_CFG
    } owner_e;

    // Result register of a channel sits at the channel number itself.
    function automatic logic [DRP_AW-1:0] sample_addr(input logic [CHAN_W-1:0] chan);
        return {2'b00, chan};
    endfunction

endpackage

// File: rtl/xadc_drp_scheduler.sv
// Shares the XADC DRP port between the end-of-conversion sample path and a
// host configuration port, with overrun detection and a DRP timeout.
module xadc_drp_scheduler
    import xadc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                eoc_i,
    input  logic [CHAN_W-1:0]   channel_i,
    input  logic                cfg_req_i,
    input  logic                cfg_we_i,
    input  logic [DRP_AW-1:0]   cfg_addr_i,
    input  logic [DRP_DW-1:0]   cfg_wdata_i,
    output logic                cfg_ack_o,
    output logic [DRP_DW-1:0]   cfg_rdata_o,
    output logic                cfg_err_o,
    output logic                drp_den_o,
    output logic                drp_dwe_o,
    output logic [DRP_AW-1:0]   drp_daddr_o,
    output logic [DRP_DW-1:0]   drp_di_o,
    input  logic                drp_drdy_i,
    input  logic [DRP_DW-1:0]   drp_do_i,
    output logic [SAMPLE_W-1:0] sample_data_o,
    output logic [CHAN_W-1:0]   sample_chan_o,
    output logic                sample_valid_o,
    output logic                overrun_o,
    output logic                timeout_o,
    output logic                busy_o
);

    // Timer holds the number of cycles elapsed since DEN.
    localparam logic [9:0] TMO_LAST = 10'(TIMEOUT_CYCLES - 1);

    state_e                state_q, state_d;
    owner_e                owner_q, owner_d;
    logic                  last_cfg_q, last_cfg_d;
    logic                  settle_q, settle_d;
    logic                  pend_q, pend_d;
    logic [CHAN_W-1:0]     pend_chan_q, pend_chan_d;
    logic [DRP_AW-1:0]     addr_q, addr_d;
    logic [DRP_DW-1:0]     di_q, di_d;
    logic                  dwe_q, dwe_d;
    logic [9:0]            timer_q, timer_d;
    logic                  cfg_ack_q, cfg_ack_d;
    logic [DRP_DW-1:0]     cfg_rdata_q, cfg_rdata_d;
    logic                  cfg_err_q, cfg_err_d;
    logic                  sample_valid_q, sample_valid_d;
    logic [SAMPLE_W-1:0]   sample_data_q, sample_data_d;
    logic [CHAN_W-1:0]     sample_chan_q, sample_chan_d;
    logic                  overrun_q, overrun_d;
    logic                  timeout_q, timeout_d;

    logic                  arb_open;
    logic                  cfg_elig;
    logic                  grant_cfg;
    logic                  grant_sample;

    // Arbitration: pending sample first, except cfg wins right after a sample
    // grant. No grant in the cycle a completion is reported, so back-to-back
    // accesses are spaced by one extra IDLE cycle.
    always_comb begin
        arb_open     = (state_q == IDLE) && !settle_q;
        cfg_elig     = cfg_req_i && !cfg_ack_q;
        grant_cfg    = arb_open && cfg_elig && (!pend_q || !last_cfg_q);
        grant_sample = arb_open && pend_q && !grant_cfg;
    end

    // Sample pending latch: newest conversion wins, overwriting a pending one flags overrun.
    always_comb begin
        pend_d      = pend_q;
        pend_chan_d = pend_chan_q;
        overrun_d   = 1'b0;
        if (grant_sample) begin
            pend_d = 1'b0;
        end
        if (eoc_i) begin
            pend_d      = 1'b1;
            pend_chan_d = channel_i;
            overrun_d   = pend_q && !grant_sample;
        end
    end

    // Transaction FSM: next state, DRP request registers and completion pulses.
    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        last_cfg_d     = last_cfg_q;
        settle_d       = 1'b0;
        addr_d         = addr_q;
        di_d           = di_q;
        dwe_d          = dwe_q;
        timer_d        = timer_q;
        cfg_ack_d      = 1'b0;
        cfg_rdata_d    = cfg_rdata_q;
        cfg_err_d      = cfg_err_q;
        sample_valid_d = 1'b0;
        sample_data_d  = sample_data_q;
        sample_chan_d  = sample_chan_q;
        timeout_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_cfg) begin
                    addr_d     = cfg_addr_i;
                    di_d       = cfg_wdata_i;
                    dwe_d      = cfg_we_i;
                    owner_d    = OWN_CFG;
                    last_cfg_d = 1'b1;
                    state_d    = ISSUE;
                end else if (grant_sample) begin
                    addr_d     = sample_addr(pend_chan_q);
                    di_d       = '0;
                    dwe_d      = 1'b0;
                    owner_d    = OWN_SAMPLE;
                    last_cfg_d = 1'b0;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = 10'd1;
                state_d = WAIT;
            end
            WAIT: begin
                timer_d = timer_q + 10'd1;
                if (drp_drdy_i) begin
                    state_d  = IDLE;
                    settle_d = 1'b1;
                    if (owner_q == OWN_CFG) begin
                        cfg_ack_d   = 1'b1;
                        cfg_rdata_d = dwe_q ? '0 : drp_do_i;
                        cfg_err_d   = 1'b0;
                    end else begin
                        sample_valid_d = 1'b1;
                        sample_data_d  = drp_do_i[DRP_DW-1:DRP_DW-SAMPLE_W];
                        sample_chan_d  = addr_q[CHAN_W-1:0];
                    end
                end else if (timer_q == TMO_LAST) begin
                    state_d   = IDLE;
                    settle_d  = 1'b1;
                    timeout_d = 1'b1;
                    if (owner_q == OWN_CFG) begin
                        cfg_ack_d   = 1'b1;
                        cfg_rdata_d = '0;
                        cfg_err_d   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            owner_q        <= OWN_CFG;
            last_cfg_q     <= 1'b1;
            settle_q       <= 1'b0;
            pend_q         <= 1'b0;
            pend_chan_q    <= '0;
            addr_q         <= '0;
            di_q           <= '0;
            dwe_q          <= 1'b0;
            timer_q        <= '0;
            cfg_ack_q      <= 1'b0;
            cfg_rdata_q    <= '0;
            cfg_err_q      <= 1'b0;
            sample_valid_q <= 1'b0;
            sample_data_q  <= '0;
            sample_chan_q  <= '0;
            overrun_q      <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            last_cfg_q     <= last_cfg_d;
            settle_q       <= settle_d;
            pend_q         <= pend_d;
            pend_chan_q    <= pend_chan_d;
            addr_q         <= addr_d;
            di_q           <= di_d;
            dwe_q          <= dwe_d;
            timer_q        <= timer_d;
            cfg_ack_q      <= cfg_ack_d;
            cfg_rdata_q    <= cfg_rdata_d;
            cfg_err_q      <= cfg_err_d;
            sample_valid_q <= sample_valid_d;
            sample_data_q  <= sample_data_d;
            sample_chan_q  <= sample_chan_d;
            overrun_q      <= overrun_d;
            timeout_q      <= timeout_d;
        end
    end

    assign drp_den_o      = (state_q == ISSUE);
    assign drp_dwe_o      = dwe_q && drp_den_o;
    assign drp_daddr_o    = addr_q;
    assign drp_di_o       = di_q;
    assign cfg_ack_o      = cfg_ack_q;
    assign cfg_rdata_o    = cfg_rdata_q;
    assign cfg_err_o      = cfg_err_q;
    assign sample_valid_o = sample_valid_q;
    assign sample_data_o  = sample_data_q;
    assign sample_chan_o  = sample_chan_q;
    assign overrun_o      = overrun_q;
    assign timeout_o      = timeout_q;
    assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_xadc_drp_scheduler.sv
// Randomised self-checking bench for xadc_drp_scheduler with a DRP responder
// model and transaction-level expectations derived from the timing rules.
module tb_xadc_drp_scheduler;
    import xadc_pkg::*;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        eoc_i;
    logic [4:0]  channel_i;
    logic        cfg_req_i, cfg_we_i;
    logic [6:0]  cfg_addr_i;
    logic [15:0] cfg_wdata_i;
    logic        cfg_ack_o, cfg_err_o;
    logic [15:0] cfg_rdata_o;
    logic        drp_den_o, drp_dwe_o, drp_drdy_i;
    logic [6:0]  drp_daddr_o;
    logic [15:0] drp_di_o, drp_do_i;
    logic [11:0] sample_data_o;
    logic [4:0]  sample_chan_o;
    logic        sample_valid_o, overrun_o, timeout_o, busy_o;

    xadc_drp_scheduler #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .eoc_i(eoc_i), .channel_i(channel_i),
        .cfg_req_i(cfg_req_i), .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i),
        .cfg_wdata_i(cfg_wdata_i), .cfg_ack_o(cfg_ack_o), .cfg_rdata_o(cfg_rdata_o),
        .cfg_err_o(cfg_err_o), .drp_den_o(drp_den_o), .drp_dwe_o(drp_dwe_o),
        .drp_daddr_o(drp_daddr_o), .drp_di_o(drp_di_o), .drp_drdy_i(drp_drdy_i),
        .drp_do_i(drp_do_i), .sample_data_o(sample_data_o), .sample_chan_o(sample_chan_o),
        .sample_valid_o(sample_valid_o), .overrun_o(overrun_o), .timeout_o(timeout_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {cfg_ack_o, cfg_rdata_o, cfg_err_o, drp_den_o, drp_dwe_o, drp_daddr_o,
                drp_di_o, sample_data_o, sample_chan_o, sample_valid_o, overrun_o,
                timeout_o, busy_o};
    endfunction

    // DRP register contents seen by the responder (the bench's model of the XADC).
    logic [15:0] mem [0:127];
    int          resp_k = 1;   // DRDY latency after DEN; 0 = never answer

    // Monitor record, cleared per scenario.
    int          den_cnt, den_cyc, valid_cnt, valid_cyc, ack_cnt, ack_cyc;
    int          ovr_cnt, tmo_cnt, tmo_cyc;
    logic [6:0]  den_addr;
    logic [15:0] den_di, ack_rdata;
    logic        den_dwe, dwe_after, prev_den, ack_err;
    logic [11:0] valid_data;
    logic [4:0]  valid_chan;
    logic [6:0]  den_q [$];

    task automatic clr_mon();
        den_cnt = 0; den_cyc = -1; valid_cnt = 0; valid_cyc = -1;
        ack_cnt = 0; ack_cyc = -1; ovr_cnt = 0; tmo_cnt = 0; tmo_cyc = -1;
        den_addr = '0; den_di = '0; den_dwe = 1'b0; dwe_after = 1'b1;
        ack_rdata = '1; ack_err = 1'bx; valid_data = '0; valid_chan = '0;
        den_q.delete();
    endtask

    // Observe DUT outputs mid-cycle; release the cfg request on its ack.
    initial begin
        prev_den = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_den) dwe_after = drp_dwe_o;
            prev_den = drp_den_o;
            if (drp_den_o) begin
                den_cnt++; den_cyc = cyc; den_addr = drp_daddr_o;
                den_dwe = drp_dwe_o; den_di = drp_di_o;
                den_q.push_back(drp_daddr_o);
            end
            if (sample_valid_o) begin
                valid_cnt++; valid_cyc = cyc; valid_data = sample_data_o; valid_chan = sample_chan_o;
            end
            if (cfg_ack_o) begin
                ack_cnt++; ack_cyc = cyc; ack_rdata = cfg_rdata_o; ack_err = cfg_err_o;
                cfg_req_i = 1'b0;
            end
            if (overrun_o) ovr_cnt++;
            if (timeout_o) begin
                tmo_cnt++; tmo_cyc = cyc;
            end
        end
    end

    // DRP responder: answers each DEN after resp_k cycles.
    initial begin : responder
        logic [6:0]  a;
        logic        w;
        logic [15:0] d;
        drp_drdy_i = 1'b0;
        drp_do_i   = '0;
        forever begin
            @(negedge clk);
            if (drp_den_o && resp_k > 0) begin
                a = drp_daddr_o; w = drp_dwe_o; d = drp_di_o;
                repeat (resp_k) @(negedge clk);
                drp_drdy_i = 1'b1;
                if (w) begin
                    drp_do_i = 16'($urandom);
                    mem[a]   = d;
                end else begin
                    drp_do_i = mem[a];
                end
                @(negedge clk);
                drp_drdy_i = 1'b0;
                drp_do_i   = 16'($urandom);
            end
        end
    end

    // One conversion on an idle scheduler: DEN two cycles after EOC, result k+1 after DEN.
    task automatic run_sample(input logic [4:0] ch, input int k);
        int          e, d;
        logic [15:0] m;
        m = mem[{2'b00, ch}];
        clr_mon();
        resp_k = k;
        @(negedge clk);
        eoc_i = 1'b1; channel_i = ch; e = cyc;
        @(negedge clk);
        eoc_i = 1'b0; channel_i = 5'($urandom);
        repeat (TMO + 6) @(negedge clk);
        d = e + 2;
        chk_eq("s_den_cyc", 64'(den_cyc), 64'(d));
        chk_eq("s_den_addr", 64'(den_addr), 64'({2'b00, ch}));
        chk_eq("s_den_dwe", 64'(den_dwe), 64'(0));
        if (k == 0) begin
            chk_eq("s_tmo_cyc", 64'(tmo_cyc), 64'(d + TMO));
            chk_eq("s_tmo_novalid", 64'(valid_cnt), 64'(0));
        end else begin
            chk_eq("s_valid_cyc", 64'(valid_cyc), 64'(d + k + 1));
            chk_eq("s_valid_data", 64'(valid_data), 64'(m[15:4]));
            chk_eq("s_valid_chan", 64'(valid_chan), 64'(ch));
            chk_eq("s_no_tmo", 64'(tmo_cnt), 64'(0));
        end
        chk_eq("s_busy_end", 64'(busy_o), 64'(0));
        $display("txn sample ch=%0d k=%0d den@%0d valid=%0d data=%03h", ch, k, den_cyc, valid_cnt, valid_data);
    endtask

    // One host access on an idle scheduler: DEN the cycle after the request.
    task automatic run_cfg(input logic we, input logic [6:0] addr, input logic [15:0] wd, input int k);
        int          r, d;
        logic [15:0] exp_r;
        exp_r = we ? 16'h0 : mem[addr];
        clr_mon();
        resp_k = k;
        @(negedge clk);
        cfg_req_i = 1'b1; cfg_we_i = we; cfg_addr_i = addr; cfg_wdata_i = wd; r = cyc;
        repeat (TMO + 6) @(negedge clk);
        cfg_req_i = 1'b0;
        d = r + 1;
        chk_eq("c_den_cyc", 64'(den_cyc), 64'(d));
        chk_eq("c_den_addr", 64'(den_addr), 64'(addr));
        chk_eq("c_den_dwe", 64'(den_dwe), 64'(we));
        if (we) chk_eq("c_den_di", 64'(den_di), 64'(wd));
        chk_eq("c_dwe_after_den", 64'(dwe_after), 64'(0));
        chk_eq("c_ack_cnt", 64'(ack_cnt), 64'(1));
        if (k == 0) begin
            chk_eq("c_tmo_ack_cyc", 64'(ack_cyc), 64'(d + TMO));
            chk_eq("c_tmo_cyc", 64'(tmo_cyc), 64'(d + TMO));
            chk_eq("c_tmo_err", 64'(ack_err), 64'(1));
            chk_eq("c_tmo_rdata", 64'(ack_rdata), 64'(0));
        end else begin
            chk_eq("c_ack_cyc", 64'(ack_cyc), 64'(d + k + 1));
            chk_eq("c_rdata", 64'(ack_rdata), 64'(exp_r));
            chk_eq("c_err", 64'(ack_err), 64'(0));
            chk_eq("c_no_tmo", 64'(tmo_cnt), 64'(0));
        end
        chk_eq("c_busy_end", 64'(busy_o), 64'(0));
        $display("txn cfg we=%0d addr=%02h k=%0d ack@%0d rdata=%04h err=%0d", we, addr, k, ack_cyc, ack_rdata, ack_err);
    endtask

    initial begin
        int n_eoc, den_at_req, n_before;
        logic        we;
        logic [6:0]  a;
        int          k;
        for (int i = 0; i < 128; i++) mem[i] = 16'($urandom);
        rst = 1'b1; eoc_i = 1'b0; channel_i = '0;
        cfg_req_i = 1'b0; cfg_we_i = 1'b0; cfg_addr_i = '0; cfg_wdata_i = '0;
        clr_mon();
        repeat (3) @(negedge clk);
        chk_eq("rst_outs_in_reset", all_outs(), 64'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_eq("rst_outs_after", all_outs(), 64'(0));

        // Directed cases.
        mem[3] = 16'hABC0;
        run_sample(5'd3, 2);
        mem[ADDR_CFG1] = 16'h2F00;
        run_cfg(1'b0, ADDR_CFG1, 16'h0, 2);
        run_cfg(1'b1, ADDR_CFG0, 16'h0003, 2);
        run_cfg(1'b0, ADDR_CFG1, 16'h0, 0);
        run_sample(5'd7, 0);

        // Randomised single transactions.
        for (int t = 0; t < 24; t++) begin
            k = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 6));
            case ($urandom_range(0, 2))
                0: run_sample(5'($urandom_range(0, 31)), k);
                default: begin
                    we = 1'($urandom);
                    a  = 7'($urandom);
                    run_cfg(we, a, 16'($urandom), k);
                end
            endcase
        end

        // Continuous conversions every 6 cycles plus one held cfg read.
        clr_mon();
        resp_k = 2;
        n_eoc = 10;
        den_at_req = 0;
        fork
            begin
                for (int i = 0; i < n_eoc; i++) begin
                    @(negedge clk); eoc_i = 1'b1; channel_i = 5'($urandom);
                    @(negedge clk); eoc_i = 1'b0;
                    repeat (4) @(negedge clk);
                end
            end
            begin
                repeat ($urandom_range(8, 30)) @(negedge clk);
                den_at_req = den_q.size();
                cfg_req_i = 1'b1; cfg_we_i = 1'b0; cfg_addr_i = ADDR_CFG2; cfg_wdata_i = '0;
                for (int i = 0; i < 200 && ack_cnt == 0; i++) @(negedge clk);
                cfg_req_i = 1'b0;
            end
        join
        repeat (30) @(negedge clk);
        n_before = 99;
        for (int j = den_at_req; j < den_q.size(); j++) begin
            if (den_q[j] == ADDR_CFG2 && n_before == 99) n_before = j - den_at_req;
        end
        chk_eq("alt_cfg_ack", 64'(ack_cnt), 64'(1));
        chk_eq("alt_cfg_wait_le1", 64'(n_before <= 1), 64'(1));
        chk_eq("alt_eoc_accounted", 64'(valid_cnt + ovr_cnt), 64'(n_eoc));
        $display("txn alternation samples_before_cfg=%0d valid=%0d overrun=%0d", n_before, valid_cnt, ovr_cnt);

        // Two conversions while a cfg read sits in WAIT.
        clr_mon();
        resp_k = 6;
        @(negedge clk);
        cfg_req_i = 1'b1; cfg_we_i = 1'b0; cfg_addr_i = ADDR_CFG1;
        for (int i = 0; i < 10 && !drp_den_o; i++) @(negedge clk);
        chk_eq("ovr_den_seen", 64'(drp_den_o), 64'(1));
        @(negedge clk); eoc_i = 1'b1; channel_i = 5'd1;
        @(negedge clk); eoc_i = 1'b0;
        @(negedge clk); eoc_i = 1'b1; channel_i = 5'd2;
        @(negedge clk); eoc_i = 1'b0;
        repeat (20) @(negedge clk);
        chk_eq("ovr_count", 64'(ovr_cnt), 64'(1));
        chk_eq("ovr_den_total", 64'(den_cnt), 64'(2));
        chk_eq("ovr_next_addr", 64'(den_addr), 64'(7'h02));
        chk_eq("ovr_valid_chan", 64'(valid_chan), 64'(2));
        chk_eq("ovr_cfg_ack", 64'(ack_cnt), 64'(1));
        $display("txn overrun pulses=%0d next_addr=%02h", ovr_cnt, den_addr);

        // Reset while WAITing, DRDY arriving one cycle later.
        clr_mon();
        resp_k = 2;
        @(negedge clk); eoc_i = 1'b1; channel_i = 5'd5;
        @(negedge clk); eoc_i = 1'b0;
        for (int i = 0; i < 10 && !drp_den_o; i++) @(negedge clk);
        chk_eq("rstw_den_seen", 64'(drp_den_o), 64'(1));
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk_eq("rstw_outs", all_outs(), 64'(0));
        repeat (6) @(negedge clk);
        chk_eq("rstw_no_valid", 64'(valid_cnt), 64'(0));
        chk_eq("rstw_no_ack", 64'(ack_cnt), 64'(0));
        chk_eq("rstw_single_den", 64'(den_cnt), 64'(1));
        chk_eq("rstw_outs_late", all_outs(), 64'(0));
        $display("txn reset_in_wait valid=%0d ack=%0d busy=%0d", valid_cnt, ack_cnt, busy_o);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
